clk_div_monitor: RTL and testbench

Receive-side checker for the divided clocks produced by the ring-counter divider. It samples a divided clock in the source clock domain and measures period and high time in source-clock cycles. It compares each measurement against expected values and reports match, lock and error status. It is used in bring-up and BIST to confirm the division ratio and duty cycle, for example 20% or 40% duty at a divide ratio of 5.

---
 rtl/clk_div_monitor.sv | 162 ++++++++++++++++
 tb/tb_clk_div_monitor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period and high time of div_in in clk cycles,
// checks them against expected values and tracks lock. Define CLK_DIV_MON_SYNC_EN
// to insert a 2-flop synchronizer on div_in for asynchronous sources.
module clk_div_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned EXP_HIGH   = 1,
  parameter int unsigned LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             match,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] ExpPeriod = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] ExpHigh   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [3:0]       LockN     = 4'(LOCK_N);

  typedef enum logic [0:0] {StIdle, StMeas} state_e;

  logic samp;

`ifdef CLK_DIV_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], div_in};
    end
  end

  assign samp = sync_q[1];
`else
  assign samp = div_in;
`endif

  state_e           state_q, state_d;
  logic             s0_q, s1_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             hfrz_q, hfrz_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mv_q, mv_d;
  logic             match_q, match_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic             rise;
  logic             hit;

  assign rise = s0_q & ~s1_q;
  assign hit  = (per_cnt_q == ExpPeriod) && (hcnt_q == ExpHigh);

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hcnt_d    = hcnt_q;
    hfrz_d    = hfrz_q;
    period_d  = period_q;
    high_d    = high_q;
    mv_d      = 1'b0;
    match_d   = match_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    mcnt_d    = mcnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d   = StMeas;
          per_cnt_d = CNT_W'(1);
          hcnt_d    = CNT_W'(1);
          hfrz_d    = 1'b0;
        end
      end
      StMeas: begin
        // A rise takes priority over a coincident timeout.
        if (rise) begin
          period_d  = per_cnt_q;
          high_d    = hcnt_q;
          mv_d      = 1'b1;
          match_d   = hit;
          per_cnt_d = CNT_W'(1);
          hcnt_d    = CNT_W'(1);
          hfrz_d    = 1'b0;
          if (hit) begin
            if (mcnt_q < LockN) begin
              mcnt_d = mcnt_q + 4'd1;
            end
            locked_d = (mcnt_d == LockN);
          end else begin
            err_d    = 1'b1;
            mcnt_d   = '0;
            locked_d = 1'b0;
          end
        end else if (per_cnt_q == CntMax) begin
          err_d    = 1'b1;
          mcnt_d   = '0;
          locked_d = 1'b0;
          state_d  = StIdle;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          if (!s0_q) begin
            hfrz_d = 1'b1;
          end else if (!hfrz_q) begin
            hcnt_d = hcnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StIdle;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      per_cnt_q <= '0;
      hcnt_q    <= '0;
      hfrz_q    <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      mv_q      <= 1'b0;
      match_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      s0_q      <= samp;
      s1_q      <= s0_q;
      per_cnt_q <= per_cnt_d;
      hcnt_q    <= hcnt_d;
      hfrz_q    <= hfrz_d;
      period_q  <= period_d;
      high_q    <= high_d;
      mv_q      <= mv_d;
      match_q   <= match_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign match      = match_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomised bench for clk_div_monitor: two instances (default and CNT_W=4/EXP_HIGH=2)
// share div_in and are checked every cycle against a sample-history model.
module tb_clk_div_monitor;

  logic clk = 1'b0;
  logic clr;
  logic div_in;

  always #5 clk = ~clk;

  logic [7:0] a_period, a_high;
  logic       a_mv, a_match, a_locked, a_err;
  logic [3:0] b_period, b_high;
  logic       b_mv, b_match, b_locked, b_err;

  clk_div_monitor u_a (
    .clk        (clk),
    .clr        (clr),
    .div_in     (div_in),
    .period     (a_period),
    .high_time  (a_high),
    .meas_valid (a_mv),
    .match      (a_match),
    .locked     (a_locked),
    .err        (a_err)
  );

  clk_div_monitor #(
    .CNT_W      (4),
    .EXP_PERIOD (5),
    .EXP_HIGH   (2),
    .LOCK_N     (4)
  ) u_b (
    .clk        (clk),
    .clr        (clr),
    .div_in     (div_in),
    .period     (b_period),
    .high_time  (b_high),
    .meas_valid (b_mv),
    .match      (b_match),
    .locked     (b_locked),
    .err        (b_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: history of effective samples; a measurement is the distance between rises.
  bit  hist [16384];
  int  n_cyc = 0;
  bit  prev_e, dl0, dl1;
  bit  m_armed [2];
  int  m_n0 [2];
  int  m_mcnt [2];
  int  exp_period [2];
  int  exp_high [2];
  bit  exp_mv [2];
  bit  exp_match [2];
  bit  exp_locked [2];
  bit  exp_err [2];
  int  mv_total [2];
  int  err_total [2];

  function automatic int max_cnt(input int i);
    return (i == 0) ? 255 : 15;
  endfunction

  function automatic int exp_h(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic model_reset();
    prev_e = 1'b0;
    dl0    = 1'b0;
    dl1    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_armed[i]    = 1'b0;
      m_mcnt[i]     = 0;
      exp_period[i] = 0;
      exp_high[i]   = 0;
      exp_mv[i]     = 1'b0;
      exp_match[i]  = 1'b0;
      exp_locked[i] = 1'b0;
      exp_err[i]    = 1'b0;
    end
  endtask

  task automatic model_step(input bit raw);
    bit e;
    bit rise;
    int per;
    int hi;
`ifdef CLK_DIV_MON_SYNC_EN
    e   = dl1;
    dl1 = dl0;
    dl0 = raw;
`else
    e = raw;
`endif
    n_cyc++;
    hist[n_cyc % 16384] = e;
    rise   = e & ~prev_e;
    prev_e = e;
    for (int i = 0; i < 2; i++) begin
      exp_mv[i]  = 1'b0;
      exp_err[i] = 1'b0;
      if (!m_armed[i]) begin
        if (rise) begin
          m_armed[i] = 1'b1;
          m_n0[i]    = n_cyc;
        end
      end else if (rise) begin
        per = n_cyc - m_n0[i];
        hi  = 0;
        while (hi < per && hist[(m_n0[i] + hi) % 16384]) hi++;
        exp_period[i] = per;
        exp_high[i]   = hi;
        exp_mv[i]     = 1'b1;
        exp_match[i]  = (per == 5) && (hi == exp_h(i));
        if (exp_match[i]) begin
          if (m_mcnt[i] < 4) m_mcnt[i]++;
        end else begin
          exp_err[i] = 1'b1;
          m_mcnt[i]  = 0;
        end
        exp_locked[i] = (m_mcnt[i] == 4);
        m_n0[i]       = n_cyc;
        mv_total[i]++;
        if (exp_err[i]) err_total[i]++;
      end else if (n_cyc - m_n0[i] == max_cnt(i)) begin
        exp_err[i]    = 1'b1;
        exp_locked[i] = 1'b0;
        m_mcnt[i]     = 0;
        m_armed[i]    = 1'b0;
        err_total[i]++;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!clr) model_reset();
    chk("a.period", int'(a_period), exp_period[0]);
    chk("a.high_time", int'(a_high), exp_high[0]);
    chk("a.meas_valid", int'(a_mv), int'(exp_mv[0]));
    chk("a.match", int'(a_match), int'(exp_match[0]));
    chk("a.locked", int'(a_locked), int'(exp_locked[0]));
    chk("a.err", int'(a_err), int'(exp_err[0]));
    chk("b.period", int'(b_period), exp_period[1]);
    chk("b.high_time", int'(b_high), exp_high[1]);
    chk("b.meas_valid", int'(b_mv), int'(exp_mv[1]));
    chk("b.match", int'(b_match), int'(exp_match[1]));
    chk("b.locked", int'(b_locked), int'(exp_locked[1]));
    chk("b.err", int'(b_err), int'(exp_err[1]));
    if (clr) model_step(div_in);
  end

  task automatic drive(input bit v);
    @(negedge clk);
    div_in = v;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) drive(c < h);
    end
  endtask

  int mv0, mv1, e0, e1;

  initial begin
    clr    = 1'b0;
    div_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.a_period", int'(a_period), 0);
    chk("rst.b_locked", int'(b_locked), 0);
    @(negedge clk);
    clr = 1'b1;

    // 20% duty: a locks, b mismatches.
    mv0 = mv_total[0];
    e0  = err_total[0];
    wave(5, 1, 8);
    #1;
    chk("s1.a_mv_count", mv_total[0] - mv0, 7);
    chk("s1.a_err_count", err_total[0] - e0, 0);
    chk("s1.a_period", int'(a_period), 5);
    chk("s1.a_high", int'(a_high), 1);
    chk("s1.a_locked", int'(a_locked), 1);
    chk("s1.b_locked", int'(b_locked), 0);

    // 40% duty: a errors on every measurement, b locks.
    e0 = err_total[0];
    e1 = err_total[1];
    wave(5, 2, 8);
    #1;
    chk("s2.a_err_count", err_total[0] - e0, 7);
    chk("s2.b_err_count", err_total[1] - e1, 1);
    chk("s2.a_high", int'(a_high), 2);
    chk("s2.a_locked", int'(a_locked), 0);
    chk("s2.b_locked", int'(b_locked), 1);

    // One stretched period drops b's lock; four good ones restore it.
    wave(6, 2, 1);
    wave(5, 2, 1);
    #1;
    chk("s3.b_period", int'(b_period), 6);
    chk("s3.b_locked", int'(b_locked), 0);
    wave(5, 2, 4);
    #1;
    chk("s3.b_relock", int'(b_locked), 1);

    // Stuck low: both time out once, last measurement held.
    e0 = err_total[0];
    e1 = err_total[1];
    repeat (300) drive(1'b0);
    #1;
    chk("s4.a_timeouts", err_total[0] - e0, 1);
    chk("s4.b_timeouts", err_total[1] - e1, 1);
    chk("s4.b_locked", int'(b_locked), 0);
    chk("s4.b_period", int'(b_period), 5);
    chk("s4.b_high", int'(b_high), 2);

    // Restart: the first rise only arms the measurement.
    mv1 = mv_total[1];
    wave(5, 2, 1);
    #1;
    chk("s5.b_mv_first", mv_total[1] - mv1, 0);
    wave(5, 2, 1);
    #1;
    chk("s5.b_mv_second", mv_total[1] - mv1, 1);

    // Reset mid-period.
    drive(1'b1);
    drive(1'b0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("s6.b_period_rst", int'(b_period), 0);
    chk("s6.a_high_rst", int'(a_high), 0);
    repeat (2) @(negedge clk);
    clr  = 1'b1;
    mv1  = mv_total[1];
    wave(5, 2, 1);
    #1;
    chk("s6.b_mv_first", mv_total[1] - mv1, 0);
    wave(5, 2, 1);
    #1;
    chk("s6.b_mv_second", mv_total[1] - mv1, 1);
    chk("s6.b_period", int'(b_period), 5);

    // Stuck high also times out.
    e1 = err_total[1];
    repeat (40) drive(1'b1);
    #1;
    chk("s7.b_stuck_high", err_total[1] - e1, 1);
    repeat (3) drive(1'b0);

    // Random periods, duties, stalls and resets.
    for (int it = 0; it < 150; it++) begin
      int p;
      int h;
      if ($urandom_range(0, 1) == 0) begin
        p = 5;
        h = $urandom_range(1, 2);
      end else begin
        p = $urandom_range(2, 20);
        h = $urandom_range(1, p - 1);
      end
      wave(p, h, $urandom_range(1, 6));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(10, 40)) drive(1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk);
        clr = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        clr = 1'b1;
      end
    end

    repeat (5) drive(1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
